// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle for the RV32IM divide sequencer.
// The master drives requests and consumes responses; the slave is the divider.
interface div_seq_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_tag, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_tag, busy
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Radix-2 restoring divider sequencer for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional result cache for DIV/REM (or DIVU/REMU) pairs on the same operands: `define DIV_FUSE_EN.
module div_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    div_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [XLEN:0]    r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_div;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [TAG_W-1:0] r_tag;
    logic             r_rsp_valid;
    logic [XLEN-1:0]  r_rsp_result;
    logic [TAG_W-1:0] r_rsp_tag;

    logic             w_accept, w_signed, w_op_rem, w_a_neg, w_b_neg, w_div0, w_ovf;
    logic [XLEN-1:0]  w_a_mag, w_b_mag;
    logic [XLEN:0]    w_shift, w_trial, w_rem_nx;
    logic             w_fit;
    logic [XLEN-1:0]  w_quo_nx, w_q_fix, w_r_fix;
    logic             w_hit;
    logic [XLEN-1:0]  w_hit_result;

    assign w_accept = bus.req_valid && (r_state == S_IDLE) && !bus.flush;
    assign w_signed = !bus.req_op[0];
    assign w_op_rem = bus.req_op[1];
    assign w_a_neg  = w_signed && bus.req_a[XLEN-1];
    assign w_b_neg  = w_signed && bus.req_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -bus.req_a : bus.req_a;
    assign w_b_mag  = w_b_neg ? -bus.req_b : bus.req_b;
    assign w_div0   = (bus.req_b == '0);
    assign w_ovf    = w_signed && (bus.req_a == MIN_INT) && (bus.req_b == '1);

    // Partial remainder stays below the divisor, so the shifted value fits XLEN+1 bits
    // and the top bit of the trial difference is the borrow.
    assign w_shift  = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
    assign w_trial  = w_shift - {1'b0, r_div};
    assign w_fit    = !w_trial[XLEN];
    assign w_rem_nx = w_fit ? w_trial : w_shift;
    assign w_quo_nx = {r_quo[XLEN-2:0], w_fit};
    assign w_q_fix  = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_fix  = r_neg_r ? -w_rem_nx[XLEN-1:0] : w_rem_nx[XLEN-1:0];

`ifdef DIV_FUSE_EN
    logic             r_c_valid;
    logic             r_c_signed;
    logic             r_signed;
    logic [XLEN-1:0]  r_c_a, r_c_b, r_c_quo, r_c_rem, r_a_raw, r_b_raw;

    assign w_hit = r_c_valid && (r_c_a == bus.req_a) && (r_c_b == bus.req_b)
                   && (r_c_signed == w_signed);
    assign w_hit_result = w_op_rem ? r_c_rem : r_c_quo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_valid  <= 1'b0;
            r_c_signed <= 1'b0;
            r_signed   <= 1'b0;
            r_c_a      <= '0;
            r_c_b      <= '0;
            r_c_quo    <= '0;
            r_c_rem    <= '0;
            r_a_raw    <= '0;
            r_b_raw    <= '0;
        end else if (bus.flush) begin
            r_c_valid <= 1'b0;
        end else if (w_accept) begin
            r_a_raw  <= bus.req_a;
            r_b_raw  <= bus.req_b;
            r_signed <= w_signed;
        end else if (r_state == S_CALC && r_cnt == '0) begin
            r_c_valid  <= 1'b1;
            r_c_signed <= r_signed;
            r_c_a      <= r_a_raw;
            r_c_b      <= r_b_raw;
            r_c_quo    <= w_q_fix;
            r_c_rem    <= w_r_fix;
        end
    end
`else
    assign w_hit        = 1'b0;
    assign w_hit_result = '0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_div        <= '0;
            r_is_rem     <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_tag        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
        end else if (bus.flush) begin
            r_state      <= S_IDLE;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= w_op_rem;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_tag    <= bus.req_tag;
                        if (w_div0 || w_ovf || w_hit) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_tag   <= bus.req_tag;
                            if (w_div0)
                                r_rsp_result <= w_op_rem ? bus.req_a : '1;
                            else if (w_ovf)
                                r_rsp_result <= w_op_rem ? '0 : MIN_INT;
                            else
                                r_rsp_result <= w_hit_result;
                        end else begin
                            r_state <= S_CALC;
                            r_cnt   <= CW'(XLEN - 1);
                            r_rem   <= '0;
                            r_quo   <= w_a_mag;
                            r_div   <= w_b_mag;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    if (r_cnt == '0) begin
                        r_state      <= S_DONE;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_result <= r_is_rem ? w_r_fix : w_q_fix;
                        r_rsp_tag    <= r_tag;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (r_rsp_valid && bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_tag    = r_rsp_tag;
    assign bus.busy       = (r_state == S_CALC) || (r_state == S_DONE && r_rsp_valid);
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl; latency counted in cycles from the accept edge.
module tb_div_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    div_seq_ctrl_if #(.XLEN(32), .TAG_W(5)) bus ();
    div_seq_ctrl #(.XLEN(32), .TAG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

`ifdef DIV_FUSE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 33;
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    // Starts at a negedge; returns at the negedge after the response handshake when rsp_ready=1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output int lat,
                         output logic [31:0] res, output logic [4:0] rtag);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res  = bus.rsp_result;
        rtag = bus.rsp_tag;
        if (bus.rsp_ready) @(negedge clk);
    endtask

    task automatic flush_pulse();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_result !== 32'd0
            || bus.rsp_tag !== 5'd0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state valid=%b busy=%b result=%h tag=%h ready=%b expected 0/0/0/0/1",
                     bus.rsp_valid, bus.busy, bus.rsp_result, bus.rsp_tag, bus.req_ready);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_divu();
        int lat; logic [31:0] res; logic [4:0] rtag;
        issue(2'b01, 32'd100, 32'd7, 5'd4, lat, res, rtag);
        checks++;
        if (res !== 32'd14) begin failures++; $display("FAIL divu_result got=%0d expected=14", res); end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL divu_latency got=%0d expected=33", lat); end
        checks++;
        if (rtag !== 5'd4) begin failures++; $display("FAIL divu_tag got=%0d expected=4", rtag); end
        issue(2'b11, 32'd100, 32'd7, 5'd5, lat, res, rtag);
        checks++;
        if (res !== 32'd2) begin failures++; $display("FAIL remu_result got=%0d expected=2", res); end
        checks++;
        if (lat !== HIT_LAT) begin failures++; $display("FAIL remu_latency got=%0d expected=%0d", lat, HIT_LAT); end
    endtask

    task automatic test_signed();
        int lat; logic [31:0] res; logic [4:0] rtag;
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, lat, res, rtag);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg_pos got=%h expected=fffffffd", res); end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL div_neg_pos_latency got=%0d expected=33", lat); end
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, lat, res, rtag);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_neg_pos got=%h expected=ffffffff", res); end
        issue(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd3, lat, res, rtag);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_pos_neg got=%h expected=fffffffd", res); end
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd6, lat, res, rtag);
        checks++;
        if (res !== 32'd1) begin failures++; $display("FAIL rem_pos_neg got=%h expected=00000001", res); end
    endtask

    task automatic test_special();
        int lat; logic [31:0] res; logic [4:0] rtag;
        issue(2'b00, 32'd5, 32'd0, 5'd10, lat, res, rtag);
        checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 1) begin
            failures++; $display("FAIL div_by_zero got=%h lat=%0d expected=ffffffff lat=1", res, lat);
        end
        checks++;
        if (rtag !== 5'd10) begin failures++; $display("FAIL div_by_zero_tag got=%0d expected=10", rtag); end
        issue(2'b11, 32'd5, 32'd0, 5'd11, lat, res, rtag);
        checks++;
        if (res !== 32'd5 || lat !== 1) begin
            failures++; $display("FAIL remu_by_zero got=%h lat=%0d expected=00000005 lat=1", res, lat);
        end
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, lat, res, rtag);
        checks++;
        if (res !== 32'h8000_0000 || lat !== 1) begin
            failures++; $display("FAIL div_overflow got=%h lat=%0d expected=80000000 lat=1", res, lat);
        end
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, lat, res, rtag);
        checks++;
        if (res !== 32'd0 || lat !== 1) begin
            failures++; $display("FAIL rem_overflow got=%h lat=%0d expected=00000000 lat=1", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; logic [4:0] rtag;
        bus.rsp_ready = 1'b0;
        issue(2'b01, 32'd200, 32'd7, 5'd9, lat, res, rtag);
        checks++;
        if (res !== 32'd28) begin failures++; $display("FAIL backpressure_result got=%0d expected=28", res); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd28 || bus.rsp_tag !== 5'd9
                || bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_hold cycle=%0d valid=%b result=%0d tag=%0d ready=%b busy=%b expected 1/28/9/0/1",
                         i, bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.req_ready, bus.busy);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL release_to_idle ready=%b valid=%b busy=%b expected 1/0/0",
                     bus.req_ready, bus.rsp_valid, bus.busy);
        end
        issue(2'b01, 32'd45, 32'd6, 5'd3, lat, res, rtag);
        checks++;
        if (res !== 32'd7 || rtag !== 5'd3 || lat !== 33) begin
            failures++; $display("FAIL back_to_back got=%0d tag=%0d lat=%0d expected=7 tag=3 lat=33", res, rtag, lat);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_a     = 32'd1000;
        bus.req_b     = 32'd3;
        bus.req_tag   = 5'd7;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_in_calc got=%b expected=1", bus.busy); end
        flush_pulse();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_calc ready=%b busy=%b valid=%b expected 1/0/0", bus.req_ready, bus.busy, bus.rsp_valid);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL flush_no_response got=%0d expected=0", seen); end
        bus.req_valid = 1'b1;
        bus.req_a     = 32'd9;
        flush_pulse();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL flush_blocks_accept ready=%b busy=%b expected 1/0", bus.req_ready, bus.busy);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL flush_accept_no_response got=%0d expected=0", seen); end
    endtask

    task automatic test_reset_mid_calc();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_a     = 32'd12345;
        bus.req_b     = 32'd17;
        bus.req_tag   = 5'd21;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_result !== 32'd0 || bus.rsp_tag !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid_calc valid=%b busy=%b result=%h tag=%h expected all 0",
                     bus.rsp_valid, bus.busy, bus.rsp_result, bus.rsp_tag);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_to_idle ready=%b expected=1", bus.req_ready); end
    endtask

    task automatic test_fuse();
        int lat; logic [31:0] res; logic [4:0] rtag;
        flush_pulse();
        issue(2'b00, 32'd100, 32'd7, 5'd14, lat, res, rtag);
        checks++;
        if (res !== 32'd14 || lat !== 33) begin
            failures++; $display("FAIL fuse_first got=%0d lat=%0d expected=14 lat=33", res, lat);
        end
        issue(2'b10, 32'd100, 32'd7, 5'd15, lat, res, rtag);
        checks++;
        if (res !== 32'd2 || lat !== HIT_LAT || rtag !== 5'd15) begin
            failures++; $display("FAIL fuse_pair got=%0d lat=%0d tag=%0d expected=2 lat=%0d tag=15", res, lat, rtag, HIT_LAT);
        end
        flush_pulse();
        issue(2'b00, 32'd100, 32'd7, 5'd16, lat, res, rtag);
        flush_pulse();
        issue(2'b10, 32'd100, 32'd7, 5'd17, lat, res, rtag);
        checks++;
        if (res !== 32'd2 || lat !== 33) begin
            failures++; $display("FAIL fuse_after_flush got=%0d lat=%0d expected=2 lat=33", res, lat);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;
        rst           = 1'b1;
        @(negedge clk);
        test_reset();
        test_divu();
        test_signed();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid_calc();
        test_fuse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
